// File: rtl/gpr_wb_queue.sv
// Writeback queue owning the GPR file write port, with newest-wins read bypass of pending writes.
// Latency: an accepted request is presented on rw/wd3/we3 the next cycle; bypass outputs are combinational.
// Backpressure: in_ready drops when all DEPTH entries are occupied; stall_wb holds the head entry in place.
module gpr_wb_queue #(
    parameter int DEPTH = 4,
    parameter int AW    = 5,
    parameter int DW    = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [AW-1:0]            in_rw,
    input  logic [DW-1:0]            in_wd,
    output logic [AW-1:0]            rw,
    output logic [DW-1:0]            wd3,
    output logic                     we3,
    input  logic                     stall_wb,
    input  logic [AW-1:0]            ra,
    input  logic [AW-1:0]            rb,
    output logic                     byp_hit_a,
    output logic                     byp_hit_b,
    output logic [DW-1:0]            byp_data_a,
    output logic [DW-1:0]            byp_data_b,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef struct packed {
        logic [AW-1:0] rw;
        logic [DW-1:0] wd;
    } entry_t;

    typedef struct packed {
        logic          hit;
        logic [DW-1:0] data;
    } byp_t;

    entry_t          mem_q [DEPTH];
    entry_t          mem_d [DEPTH];
    logic [PW-1:0]   wp_q, wp_d;
    logic [PW-1:0]   rp_q, rp_d;
    logic [CW-1:0]   count_q, count_d;

    logic            push;
    entry_t          head;
    byp_t            byp_a, byp_b;

    assign in_ready = (count_q != CW'(DEPTH));
    assign empty    = (count_q == '0);
    assign count    = count_q;
    assign we3      = !empty && !stall_wb;
    assign head     = mem_q[rp_q];
    assign rw       = empty ? '0 : head.rw;
    assign wd3      = empty ? '0 : head.wd;

    // Writes to $0 complete the handshake but are never stored.
    assign push = in_valid && in_ready && (in_rw != '0);

    // Walk occupied entries oldest to newest so the newest match overrides older ones.
    function automatic byp_t lookup(input logic [AW-1:0] addr);
        byp_t          res;
        logic [PW-1:0] idx;
        res = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = rp_q + PW'(i);
            if ((CW'(i) < count_q) && (addr != '0) && (mem_q[idx].rw == addr)) begin
                res.hit  = 1'b1;
                res.data = mem_q[idx].wd;
            end
        end
        return res;
    endfunction

    // Bypass lookups for both read ports; misses return zero data.
    always_comb begin
        byp_a      = lookup(ra);
        byp_b      = lookup(rb);
        byp_hit_a  = byp_a.hit;
        byp_data_a = byp_a.data;
        byp_hit_b  = byp_b.hit;
        byp_data_b = byp_b.data;
    end

    // Next-state: store on push, retire the head on every register-file write.
    always_comb begin
        mem_d   = mem_q;
        wp_d    = wp_q;
        rp_d    = rp_q;
        count_d = count_q;
        if (push) begin
            mem_d[wp_q] = '{rw: in_rw, wd: in_wd};
            wp_d        = wp_q + PW'(1);
        end
        if (we3) begin
            rp_d = rp_q + PW'(1);
        end
        case ({push, we3})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // State registers; reset discards every pending entry immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wp_q    <= '0;
            rp_q    <= '0;
            count_q <= '0;
        end else begin
            mem_q   <= mem_d;
            wp_q    <= wp_d;
            rp_q    <= rp_d;
            count_q <= count_d;
        end
    end
endmodule

// File: tb/tb_gpr_wb_queue.sv
// Directed bench for gpr_wb_queue with a scoreboard of pending writes.
// Each step samples outputs at the falling edge against the scoreboard, then commits at the rising edge.
// Directed checks cover reset, fill/stall, newest-wins bypass, $0 discard, pointer wrap and reset mid-drain.
module tb_gpr_wb_queue;
    localparam int DEPTH = 4;
    localparam int AW    = 5;
    localparam int DW    = 32;

    typedef struct packed {
        logic [AW-1:0] rw;
        logic [DW-1:0] wd;
    } ent_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [AW-1:0] in_rw = '0;
    logic [DW-1:0] in_wd = '0;
    logic [AW-1:0] rw;
    logic [DW-1:0] wd3;
    logic          we3;
    logic          stall_wb = 1'b0;
    logic [AW-1:0] ra = '0;
    logic [AW-1:0] rb = '0;
    logic          byp_hit_a, byp_hit_b;
    logic [DW-1:0] byp_data_a, byp_data_b;
    logic [2:0]    count;
    logic          empty;

    int   errors = 0;
    int   checks = 0;
    ent_t sb[$];

    always #5 clk = ~clk;

    gpr_wb_queue #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_rw(in_rw), .in_wd(in_wd),
        .rw(rw), .wd3(wd3), .we3(we3), .stall_wb(stall_wb),
        .ra(ra), .rb(rb),
        .byp_hit_a(byp_hit_a), .byp_hit_b(byp_hit_b),
        .byp_data_a(byp_data_a), .byp_data_b(byp_data_b),
        .count(count), .empty(empty)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Newest pending write to addr, from the scoreboard contents.
    task automatic byp_model(input logic [AW-1:0] addr, output logic h, output logic [DW-1:0] d);
        h = 1'b0;
        d = '0;
        if (addr != '0) begin
            foreach (sb[i]) begin
                if (sb[i].rw == addr) begin
                    h = 1'b1;
                    d = sb[i].wd;
                end
            end
        end
    endtask

    // One clock cycle: check all outputs against the scoreboard, update it, then let the edge commit.
    task automatic step();
        int            n;
        logic          eh;
        logic [DW-1:0] ed;
        ent_t          e;
        @(negedge clk);
        n = sb.size();
        chk("count", 64'(count), 64'(n));
        chk("empty", 64'(empty), 64'(n == 0));
        chk("in_ready", 64'(in_ready), 64'(n != DEPTH));
        chk("we3", 64'(we3), 64'((n != 0) && !stall_wb));
        e = (n != 0) ? sb[0] : '0;
        chk("rw", 64'(rw), 64'(e.rw));
        chk("wd3", 64'(wd3), 64'(e.wd));
        byp_model(ra, eh, ed);
        chk("byp_hit_a", 64'(byp_hit_a), 64'(eh));
        chk("byp_data_a", 64'(byp_data_a), 64'(ed));
        byp_model(rb, eh, ed);
        chk("byp_hit_b", 64'(byp_hit_b), 64'(eh));
        chk("byp_data_b", 64'(byp_data_b), 64'(ed));
        if ((n != 0) && !stall_wb) void'(sb.pop_front());
        if (in_valid && (n != DEPTH) && (in_rw != '0)) sb.push_back('{rw: in_rw, wd: in_wd});
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [AW-1:0] r, input logic [DW-1:0] d);
        in_valid = 1'b1;
        in_rw    = r;
        in_wd    = d;
        step();
        in_valid = 1'b0;
    endtask

    initial begin
        // Reset state
        ra = 5'd3;
        rb = 5'd3;
        #2;
        chk("rst_empty", 64'(empty), 64'd1);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_we3", 64'(we3), 64'd0);
        chk("rst_rw", 64'(rw), 64'd0);
        chk("rst_wd3", 64'(wd3), 64'd0);
        chk("rst_hit_a", 64'(byp_hit_a), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // 1: single write, presented the cycle after acceptance
        push(5'd3, 32'h1234);
        #1;
        chk("t1_we3", 64'(we3), 64'd1);
        chk("t1_rw", 64'(rw), 64'd3);
        chk("t1_wd3", 64'(wd3), 64'h1234);
        chk("t1_byp_a", 64'(byp_data_a), 64'h1234);
        step();
        chk("t1_empty", 64'(empty), 64'd1);

        // 2: fill under stall, fifth push refused, drain in order
        stall_wb = 1'b1;
        for (int r = 1; r <= 5; r++) begin
            push(AW'(r), DW'(r * 32'h11));
            if (r == 4) begin
                chk("t2_count_full", 64'(count), 64'd4);
                chk("t2_ready_full", 64'(in_ready), 64'd0);
            end
        end
        chk("t2_count_hold", 64'(count), 64'd4);
        stall_wb = 1'b0;
        ra = 5'd4;
        rb = 5'd5;
        #1;
        chk("t2_head_rw", 64'(rw), 64'd1);
        step();
        chk("t2_ready_back", 64'(in_ready), 64'd1);
        repeat (3) step();
        chk("t2_drained", 64'(empty), 64'd1);

        // 3: newest-wins bypass
        stall_wb = 1'b1;
        push(5'd7, 32'hA);
        push(5'd7, 32'hB);
        push(5'd9, 32'hC);
        ra = 5'd7;
        rb = 5'd9;
        #1;
        chk("t3_hit_a", 64'(byp_hit_a), 64'd1);
        chk("t3_data_a", 64'(byp_data_a), 64'hB);
        chk("t3_hit_b", 64'(byp_hit_b), 64'd1);
        chk("t3_data_b", 64'(byp_data_b), 64'hC);
        ra = 5'd8;
        #1;
        chk("t3_miss_a", 64'(byp_hit_a), 64'd0);
        chk("t3_miss_data", 64'(byp_data_a), 64'd0);
        step();
        stall_wb = 1'b0;
        ra = 5'd7;
        repeat (3) step();

        // 4: writes to $0 are accepted and dropped
        in_valid = 1'b1;
        in_rw    = 5'd0;
        in_wd    = 32'hFFFF;
        #1;
        chk("t4_ready", 64'(in_ready), 64'd1);
        step();
        in_valid = 1'b0;
        ra = 5'd0;
        rb = 5'd0;
        #1;
        chk("t4_count", 64'(count), 64'd0);
        chk("t4_hit_a", 64'(byp_hit_a), 64'd0);
        repeat (2) step();

        // 5: push every cycle through two pointer wraps
        for (int i = 0; i < 3 * DEPTH; i++) begin
            ra = AW'(((i + 30) % 31) + 1);
            push(AW'((i % 31) + 1), $urandom);
            chk("t5_count", 64'(count), 64'd1);
            in_valid = 1'b1;
        end
        in_valid = 1'b0;
        step();
        chk("t5_empty", 64'(empty), 64'd1);

        // 6: asynchronous reset while entries are pending
        stall_wb = 1'b1;
        push(5'd4, 32'h44);
        push(5'd5, 32'h55);
        push(5'd6, 32'h66);
        stall_wb = 1'b0;
        ra = 5'd5;
        rb = 5'd6;
        #2;
        chk("t6_we3_pre", 64'(we3), 64'd1);
        chk("t6_hit_pre", 64'(byp_hit_a), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("t6_we3", 64'(we3), 64'd0);
        chk("t6_count", 64'(count), 64'd0);
        chk("t6_hit_a", 64'(byp_hit_a), 64'd0);
        chk("t6_hit_b", 64'(byp_hit_b), 64'd0);
        chk("t6_rw", 64'(rw), 64'd0);
        sb.delete();
        rst_n = 1'b1;
        repeat (4) step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Overall time bound so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
